// File: rtl/shift_unit_seq.sv
// Multi-cycle LSL/LSR/ASR/ROR shifter with Thumb register-amount semantics.
// It moves up to STEP bits per cycle and updates N/Z/C when S is set.
module shift_unit_seq #(
   parameter int WIDTH = 32,
   parameter int AMT_W = 8,
   parameter int STEP  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             S,
   input  logic [1:0]       stype,
   input  logic [WIDTH-1:0] Rm,
   input  logic [AMT_W-1:0] amount,
   input  logic             carry_in,
   input  logic             zero_in,
   input  logic             neg_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Rd,
   output logic             carry_out,
   output logic             zero_out,
   output logic             neg_out
);

   localparam int CNT_W = $clog2(WIDTH + 2);
   localparam logic [CNT_W-1:0] STEP_C  = CNT_W'(STEP);
   localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] SAT_C   = CNT_W'(WIDTH + 1);

   localparam logic [1:0] T_LSL = 2'b00;
   localparam logic [1:0] T_LSR = 2'b01;
   localparam logic [1:0] T_ASR = 2'b10;
   localparam logic [1:0] T_ROR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] work_r;
   logic [CNT_W-1:0] cnt_r;
   logic             c_int_r;
   logic             s_flag_r;
   logic [1:0]       stype_r;
   logic             sign_r;
   logic             amt_nz_r;
   logic             cin_r;
   logic             zin_r;
   logic             nin_r;

   logic [31:0]      amt_ext_s;
   logic [CNT_W-1:0] load_cnt_s;
   logic [CNT_W-1:0] step_s;
   logic [WIDTH:0]   lsl_ext_s;
   logic [WIDTH:0]   rsh_ext_s;
   logic [WIDTH:0]   asr_ext_s;
   logic [WIDTH-1:0] ror_s;
   logic [WIDTH-1:0] nxt_work_s;
   logic             shift_c_s;
   logic             nxt_c_s;
   logic             last_step_s;
   logic             res_c_s;
   logic             res_z_s;
   logic             res_n_s;

   // Initial step count: saturates at WIDTH+1 for shifts, wraps modulo WIDTH for rotates.
   always_comb begin
      amt_ext_s  = 32'(amount);
      load_cnt_s = {CNT_W{1'b0}};
      if (stype == T_ROR) begin
         load_cnt_s = CNT_W'(amt_ext_s % 32'(WIDTH));
      end else if (amt_ext_s > 32'(WIDTH + 1)) begin
         load_cnt_s = SAT_C;
      end else begin
         load_cnt_s = CNT_W'(amt_ext_s);
      end
   end

   // One shift step; the extra bit of each extended vector is the bit shifted out.
   always_comb begin
      step_s = cnt_r;
      if (cnt_r > STEP_C) begin
         step_s = STEP_C;
      end else begin
         step_s = cnt_r;
      end
      lsl_ext_s = {1'b0, work_r} << step_s;
      rsh_ext_s = {work_r, 1'b0} >> step_s;
      if (sign_r) begin
         asr_ext_s = rsh_ext_s | ~({(WIDTH + 1){1'b1}} >> step_s);
      end else begin
         asr_ext_s = rsh_ext_s;
      end
      ror_s = (work_r >> step_s) | (work_r << (WIDTH_C - step_s));
      case (stype_r)
         T_LSL: begin
            nxt_work_s = lsl_ext_s[WIDTH-1:0];
            shift_c_s  = lsl_ext_s[WIDTH];
         end
         T_LSR: begin
            nxt_work_s = rsh_ext_s[WIDTH:1];
            shift_c_s  = rsh_ext_s[0];
         end
         T_ASR: begin
            nxt_work_s = asr_ext_s[WIDTH:1];
            shift_c_s  = asr_ext_s[0];
         end
         T_ROR: begin
            nxt_work_s = ror_s;
            shift_c_s  = c_int_r;
         end
         default: begin
            nxt_work_s = work_r;
            shift_c_s  = c_int_r;
         end
      endcase
      if ((step_s != {CNT_W{1'b0}}) && (stype_r != T_ROR)) begin
         nxt_c_s = shift_c_s;
      end else begin
         nxt_c_s = c_int_r;
      end
      last_step_s = (cnt_r <= STEP_C);
   end

   // Flags presented together with the final result.
   always_comb begin
      res_c_s = cin_r;
      res_z_s = zin_r;
      res_n_s = nin_r;
      if (s_flag_r) begin
         res_n_s = nxt_work_s[WIDTH-1];
         res_z_s = (nxt_work_s == {WIDTH{1'b0}});
         if (stype_r == T_ROR) begin
            res_c_s = amt_nz_r ? nxt_work_s[WIDTH-1] : cin_r;
         end else begin
            res_c_s = nxt_c_s;
         end
      end else begin
         res_c_s = cin_r;
         res_z_s = zin_r;
         res_n_s = nin_r;
      end
   end

   // Control FSM, working registers and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= ST_IDLE;
         work_r    <= {WIDTH{1'b0}};
         cnt_r     <= {CNT_W{1'b0}};
         c_int_r   <= 1'b0;
         s_flag_r  <= 1'b0;
         stype_r   <= 2'b00;
         sign_r    <= 1'b0;
         amt_nz_r  <= 1'b0;
         cin_r     <= 1'b0;
         zin_r     <= 1'b0;
         nin_r     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         Rd        <= {WIDTH{1'b0}};
         carry_out <= 1'b0;
         zero_out  <= 1'b0;
         neg_out   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  work_r   <= Rm;
                  cnt_r    <= load_cnt_s;
                  c_int_r  <= carry_in;
                  s_flag_r <= S;
                  stype_r  <= stype;
                  sign_r   <= Rm[WIDTH-1];
                  amt_nz_r <= (amount != {AMT_W{1'b0}});
                  cin_r    <= carry_in;
                  zin_r    <= zero_in;
                  nin_r    <= neg_in;
                  busy     <= 1'b1;
                  state_r  <= ST_SHIFT;
               end else begin
                  busy <= 1'b0;
               end
            end
            ST_SHIFT: begin
               work_r  <= nxt_work_s;
               cnt_r   <= cnt_r - step_s;
               c_int_r <= nxt_c_s;
               if (last_step_s) begin
                  Rd        <= nxt_work_s;
                  carry_out <= res_c_s;
                  zero_out  <= res_z_s;
                  neg_out   <= res_n_s;
                  done      <= 1'b1;
                  state_r   <= ST_DONE;
               end else begin
                  done <= 1'b0;
               end
            end
            ST_DONE: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
